t06_wall_spawn_ctrl: RTL and testbench
======================================

Name: t06_wall_spawn_ctrl

Overview:
- Sequences placement of random obstacle walls in wall mode.
- Counts apples eaten and waits a fixed delay. It then pulls candidate cells from the random-coordinate source and screens each against the board bounds, the snake head and the external body/wall collision checker.
- Commits the first legal cell into a shift-register wall list.
- Sits between the random generator, the collision logic and the wall/pixel renderer. It replaces the ad-hoc good_spot clocking with one synchronous FSM.

Parameters:
- MAX_WALLS, 25, capacity of the wall list (entries of 8 bits, {y[3:0],x[3:0]}).
- APPLES_PER_WALL, 2, good_collision pulses needed to arm one spawn.
- SPAWN_DELAY, 30, cycles between arming and the first candidate request.
- MAX_TRIES, 15, candidates screened per spawn before giving up.

Ports:
- system_clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable_in  in  1  wall mode active; low synchronously clears the list and forces IDLE
- good_collision  in  1  one-cycle pulse per apple eaten
- snake_head_x  in  4  current head x
- snake_head_y  in  4  current head y
- XMAX, XMIN, YMAX, YMIN  in  4 each  board bounds (exclusive)
- cand_req  out  1  request for a new random candidate
- cand_valid  in  1  candidate available
- cand_xy  in  8  candidate {y,x}
- chk_xy  out  8  registered cell presented to the collision checker
- chk_hit  in  1  combinational body-or-wall hit for chk_xy, valid in the same cycle
- walls  out  MAX_WALLS*8  wall list; entry 0 = newest; 8'h00 = empty slot
- wall_count  out  5  number of valid entries
- busy  out  1  FSM not in IDLE
- place_done  out  1  one-cycle pulse on commit
- place_fail  out  1  one-cycle pulse on try exhaustion

Behaviour:
- Reset: walls=0, wall_count=0, chk_xy=0, cand_req=0, busy=0, place_done=0, place_fail=0, apple counter=0, delay counter=0, try counter=0, state=IDLE.
- enable_in=0: same clearing as reset, with priority below reset. good_collision is ignored.
- Apple counter: increments on good_collision while enable_in=1, in any state.
  - When it reaches APPLES_PER_WALL, it wraps to 0 and sets pending.
  - A second arm while pending is already set is dropped; pending saturates at 1.
- FSM states:
  - IDLE: if pending and wall_count<MAX_WALLS, go to WAIT, clear pending, load delay=SPAWN_DELAY. If pending and the list is full, clear pending and stay in IDLE (no fail pulse).
  - WAIT: decrement delay each cycle. At delay==1, go to REQ. First cand_req is asserted exactly SPAWN_DELAY cycles after leaving IDLE.
  - REQ: cand_req=1. It holds until cand_valid. On a cycle with cand_req&cand_valid: latch chk_xy<=cand_xy, try counter +1, go to CHECK. cand_req deasserts in the cycle after the handshake.
  - CHECK: one cycle; evaluate legality. A cell is illegal if any of: x<=XMIN, x>=XMAX, y<=YMIN, y>=YMAX, {y,x}=={snake_head_y,snake_head_x}, chk_hit=1.
    - Legal: go to COMMIT.
    - Illegal and tries<MAX_TRIES: go to REQ.
    - Illegal and tries==MAX_TRIES: pulse place_fail, go to IDLE.
  - COMMIT: walls<={walls[(MAX_WALLS-1)*8-1:0], chk_xy}, wall_count+1, pulse place_done, clear tries, go to IDLE. The commit is visible on walls the cycle after COMMIT.
- Counters:
  - Try counter is 4 bits and clears on entry to WAIT.
  - wall_count saturates at MAX_WALLS; the list never shifts out a valid entry because IDLE blocks spawning when full.
- Simultaneous events:
  - good_collision during WAIT/REQ/CHECK is counted and may set pending. Pending is serviced on the next IDLE.
  - enable_in falling mid-operation aborts with no pulses.
- chk_hit is sampled only in CHECK. Bounds compare as unsigned 4-bit.

Test Plan:
- Reset, enable_in=1, 2 good_collision pulses -> busy rises next cycle; cand_req rises 30 cycles later; cand_xy=8'h55 (bounds 0/15, head 3,3, chk_hit=0) -> place_done pulse, walls[7:0]=8'h55, wall_count=1.
- Candidates 8'h33 (head), 8'h0F (x>=XMAX), then 8'h47 with chk_hit=1, then 8'h48 clean -> 4 handshakes, only 8'h48 committed.
- 15 consecutive illegal candidates -> place_fail pulse after the 15th CHECK; no cand_req afterwards; wall_count unchanged.
- Commit 25 walls, then 2 more apples -> busy stays 0; walls unchanged; entry 24 = first committed value.
- enable_in dropped in REQ with wall_count=3 -> next cycle state IDLE, walls=0, wall_count=0, cand_req=0; reset asserted mid-WAIT gives the same result.
- 4 good_collision pulses during one WAIT -> exactly one further spawn after the current one completes.

Source files
------------

// File: rtl/t06_wall_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// t06_wall_spawn_ctrl
//   Wall-mode obstacle sequencer. Counts apples, arms a spawn every
//   APPLES_PER_WALL apples, waits SPAWN_DELAY cycles, then pulls candidate
//   cells from the random source and screens each one against the board
//   bounds, the snake head and the external body/wall checker. The first
//   legal cell is pushed into a shift-register wall list (entry 0 = newest).
//
// Ports
//   system_clk, reset          clock, synchronous active-high reset
//   enable_in                  wall mode; low clears the list and idles the FSM
//   good_collision             one-cycle pulse per apple eaten
//   snake_head_x/y             current head cell
//   XMAX/XMIN/YMAX/YMIN        exclusive board bounds (unsigned 4-bit)
//   cand_req/cand_valid/cand_xy  candidate handshake with the random source
//   chk_xy/chk_hit             cell under test and its body-or-wall hit
//   walls, wall_count          wall list ({y,x} per byte, 8'h00 = empty)
//   busy                       FSM not idle
//   place_done                 pulse while committing a wall
//   place_fail                 pulse the cycle after the last try was rejected
// ---------------------------------------------------------------------------
module t06_wall_spawn_ctrl #(
  parameter int MAX_WALLS       = 25,
  parameter int APPLES_PER_WALL = 2,
  parameter int SPAWN_DELAY     = 30,
  parameter int MAX_TRIES       = 15
) (
  input  logic                   system_clk,
  input  logic                   reset,
  input  logic                   enable_in,
  input  logic                   good_collision,
  input  logic [3:0]             snake_head_x,
  input  logic [3:0]             snake_head_y,
  input  logic [3:0]             XMAX,
  input  logic [3:0]             XMIN,
  input  logic [3:0]             YMAX,
  input  logic [3:0]             YMIN,
  output logic                   cand_req,
  input  logic                   cand_valid,
  input  logic [7:0]             cand_xy,
  output logic [7:0]             chk_xy,
  input  logic                   chk_hit,
  output logic [MAX_WALLS*8-1:0] walls,
  output logic [4:0]             wall_count,
  output logic                   busy,
  output logic                   place_done,
  output logic                   place_fail
);

  localparam int AW = (APPLES_PER_WALL > 1) ? $clog2(APPLES_PER_WALL) : 1;
  localparam int DW = $clog2(SPAWN_DELAY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_CHECK,
    S_COMMIT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [AW-1:0]          r_apple;
  logic                   r_pending;
  logic [DW-1:0]          r_delay;
  logic [3:0]             r_tries;
  logic [7:0]             r_chk;
  logic [MAX_WALLS*8-1:0] r_walls;
  logic [4:0]             r_count;
  logic                   r_fail;

  logic       w_arm;
  logic       w_take;
  logic       w_full;
  logic       w_illegal;
  logic       w_out_of_tries;
  logic [3:0] w_cx;
  logic [3:0] w_cy;

  // An apple that completes the set arms a spawn in the same cycle, so an
  // idle FSM leaves IDLE right on the edge that sees the last apple instead
  // of first round-tripping through the pending flag.
  assign w_arm  = good_collision && (r_apple == AW'(APPLES_PER_WALL - 1));
  assign w_take = (r_state == S_IDLE) && (r_pending || w_arm);
  assign w_full = (r_count == 5'(MAX_WALLS));

  assign w_cx = r_chk[3:0];
  assign w_cy = r_chk[7:4];

  // Bounds are exclusive on both sides; chk_hit is only meaningful here in
  // CHECK because chk_xy is stable for that whole cycle.
  assign w_illegal = (w_cx <= XMIN) || (w_cx >= XMAX) ||
                     (w_cy <= YMIN) || (w_cy >= YMAX) ||
                     (r_chk == {snake_head_y, snake_head_x}) ||
                     chk_hit;

  assign w_out_of_tries = (r_tries >= 4'(MAX_TRIES));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_take && !w_full) w_next = S_WAIT;
      S_WAIT:   if (r_delay == DW'(1)) w_next = S_REQ;
      S_REQ:    if (cand_valid) w_next = S_CHECK;
      S_CHECK: begin
        if (!w_illegal)          w_next = S_COMMIT;
        else if (w_out_of_tries) w_next = S_IDLE;
        else                     w_next = S_REQ;
      end
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register and datapath. Dropping enable_in has the same effect as
  // reset, so both share one clearing branch (reset still dominates since
  // nothing else can override it).
  always_ff @(posedge system_clk) begin
    if (reset || !enable_in) begin
      r_state   <= S_IDLE;
      r_apple   <= '0;
      r_pending <= 1'b0;
      r_delay   <= '0;
      r_tries   <= '0;
      r_chk     <= '0;
      r_walls   <= '0;
      r_count   <= '0;
      r_fail    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fail  <= 1'b0;

      if (good_collision)
        r_apple <= w_arm ? '0 : r_apple + 1'b1;

      // Pending saturates at one; it is consumed by IDLE whether or not the
      // list has room (a full list silently drops the spawn).
      if (w_take)     r_pending <= 1'b0;
      else if (w_arm) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_take && !w_full) begin
            r_delay <= DW'(SPAWN_DELAY);
            r_tries <= '0;
          end
        end
        S_WAIT: r_delay <= r_delay - 1'b1;
        S_REQ: begin
          if (cand_valid) begin
            r_chk   <= cand_xy;
            r_tries <= r_tries + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_illegal && w_out_of_tries) r_fail <= 1'b1;
        end
        S_COMMIT: begin
          r_walls <= {r_walls[(MAX_WALLS-1)*8-1:0], r_chk};
          if (!w_full) r_count <= r_count + 1'b1;
          r_tries <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cand_req   = (r_state == S_REQ);
  assign busy       = (r_state != S_IDLE);
  assign place_done = (r_state == S_COMMIT);
  assign place_fail = r_fail;
  assign chk_xy     = r_chk;
  assign walls      = r_walls;
  assign wall_count = r_count;

endmodule

// File: tb/tb_t06_wall_spawn_ctrl.sv
module tb_t06_wall_spawn_ctrl;
  localparam int MW = 25;
  localparam int SD = 30;
  localparam int MT = 15;

  logic          system_clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable_in = 1'b0;
  logic          good_collision = 1'b0;
  logic [3:0]    snake_head_x = 4'd3;
  logic [3:0]    snake_head_y = 4'd3;
  logic [3:0]    XMAX = 4'd15;
  logic [3:0]    XMIN = 4'd0;
  logic [3:0]    YMAX = 4'd15;
  logic [3:0]    YMIN = 4'd0;
  logic          cand_req;
  logic          cand_valid = 1'b0;
  logic [7:0]    cand_xy = 8'h00;
  logic [7:0]    chk_xy;
  logic          chk_hit = 1'b0;
  logic [MW*8-1:0] walls;
  logic [4:0]    wall_count;
  logic          busy;
  logic          place_done;
  logic          place_fail;

  t06_wall_spawn_ctrl dut (
    .system_clk(system_clk), .reset(reset), .enable_in(enable_in),
    .good_collision(good_collision),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .XMAX(XMAX), .XMIN(XMIN), .YMAX(YMAX), .YMIN(YMIN),
    .cand_req(cand_req), .cand_valid(cand_valid), .cand_xy(cand_xy),
    .chk_xy(chk_xy), .chk_hit(chk_hit),
    .walls(walls), .wall_count(wall_count), .busy(busy),
    .place_done(place_done), .place_fail(place_fail)
  );

  always #5 system_clk = ~system_clk;

  int errors = 0;
  int checks = 0;

  // Reference wall list: front = newest entry.
  logic [7:0] mw[$];
  // Candidate script for the next spawn.
  logic [7:0] cq[$];
  bit         hq[$];

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge system_clk);
  endtask

  function automatic logic [MW*8-1:0] exp_walls();
    logic [MW*8-1:0] v;
    v = '0;
    foreach (mw[i]) v[i*8 +: 8] = mw[i];
    return v;
  endfunction

  function automatic bit in_list(input logic [7:0] c);
    foreach (mw[i]) if (mw[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Legality straight from the placement rules.
  function automatic bit legal(input logic [7:0] c, input bit h);
    int x, y;
    x = int'(c[3:0]);
    y = int'(c[7:4]);
    if (x <= int'(XMIN) || x >= int'(XMAX)) return 1'b0;
    if (y <= int'(YMIN) || y >= int'(YMAX)) return 1'b0;
    if (x == int'(snake_head_x) && y == int'(snake_head_y)) return 1'b0;
    return !h;
  endfunction

  // Legal cell for bounds 0/15, not the head, not already a wall.
  function automatic logic [7:0] pick_legal();
    logic [7:0] c;
    do begin
      c[3:0] = 4'($urandom_range(1, 14));
      c[7:4] = 4'($urandom_range(1, 14));
    end while ((c[3:0] == snake_head_x && c[7:4] == snake_head_y) || in_list(c));
    return c;
  endfunction

  task automatic apple();
    good_collision = 1'b1;
    tick();
    good_collision = 1'b0;
  endtask

  task automatic arm(input bit exp_busy);
    apple();
    chk("arm_first_idle", busy, 0);
    apple();
    chk("arm_busy", busy, exp_busy);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (cand_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic serve(input logic [7:0] c, input bit h);
    int n;
    wait_req(n);
    chk("req_ready", cand_req, 1);
    cand_valid = 1'b1;
    cand_xy    = c;
    chk_hit    = h;
    tick();
    cand_valid = 1'b0;
    chk("req_drop", cand_req, 0);
    chk("chk_xy", chk_xy, c);
  endtask

  // Feed the scripted candidates until one is committed or tries run out.
  task automatic run_spawn();
    bit         done;
    logic [7:0] c;
    bit         h;
    done = 1'b0;
    for (int i = 0; i < MT && i < cq.size() && !done; i++) begin
      c = cq[i];
      h = hq[i];
      serve(c, h);
      tick();
      if (legal(c, h)) begin
        chk("commit_done", place_done, 1);
        chk("commit_nofail", place_fail, 0);
        mw.push_front(c);
        tick();
        chk("commit_walls", walls, exp_walls());
        chk("commit_count", wall_count, mw.size());
        chk("commit_done_low", place_done, 0);
        chk("commit_idle", busy, 0);
        done = 1'b1;
      end else if (i < MT - 1) begin
        chk("retry_req", cand_req, 1);
        chk("retry_nodone", place_done, 0);
      end else begin
        chk("fail_pulse", place_fail, 1);
        chk("fail_idle", busy, 0);
        tick();
        chk("fail_pulse_low", place_fail, 0);
        chk("fail_no_req", cand_req, 0);
        chk("fail_count", wall_count, mw.size());
        chk("fail_walls", walls, exp_walls());
        done = 1'b1;
      end
    end
    cq.delete();
    hq.delete();
  endtask

  task automatic spawn_one_legal();
    int n;
    arm(1);
    wait_req(n);
    chk("spawn_delay", n, SD);
    cq.push_back(pick_legal());
    hq.push_back(1'b0);
    run_spawn();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    logic [7:0] c;
    logic [MW*8-1:0] wsnap;

    // Reset state
    tick(); tick();
    chk("rst_walls", walls, 0);
    chk("rst_count", wall_count, 0);
    chk("rst_chk_xy", chk_xy, 0);
    chk("rst_req", cand_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", place_done, 0);
    chk("rst_fail", place_fail, 0);
    reset = 1'b0;
    enable_in = 1'b1;
    tick();

    // First spawn: exact delay and a clean 8'h55
    arm(1);
    wait_req(n);
    chk("first_delay", n, SD);
    cq.push_back(8'h55); hq.push_back(1'b0);
    run_spawn();
    chk("first_entry", walls[7:0], 8'h55);

    // Head, out-of-bounds, checker hit, then clean
    arm(1);
    wait_req(n);
    chk("mix_delay", n, SD);
    cq = '{8'h33, 8'h0F, 8'h47, 8'h48};
    hq = '{1'b0, 1'b0, 1'b1, 1'b0};
    run_spawn();
    chk("mix_entry0", walls[7:0], 8'h48);
    chk("mix_entry1", walls[15:8], 8'h55);

    // All candidates illegal: give up after MT tries
    arm(1);
    wait_req(n);
    for (int i = 0; i < MT; i++) begin cq.push_back(8'h00); hq.push_back(1'b0); end
    run_spawn();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (cand_req || busy) seen = 1'b1; end
    chk("fail_quiet", seen, 0);

    // Third wall, then drop enable in REQ
    spawn_one_legal();
    chk("pre_drop_count", wall_count, 3);
    arm(1);
    wait_req(n);
    chk("drop_in_req", cand_req, 1);
    enable_in = 1'b0;
    tick();
    mw.delete();
    chk("drop_busy", busy, 0);
    chk("drop_walls", walls, 0);
    chk("drop_count", wall_count, 0);
    chk("drop_req", cand_req, 0);
    chk("drop_nopulse", {place_done, place_fail}, 0);
    // Apples while disabled are ignored
    apple(); apple();
    chk("disabled_apples", busy, 0);
    enable_in = 1'b1;
    tick();
    chk("reenable_idle", busy, 0);

    // One wall, then reset in the middle of WAIT
    spawn_one_legal();
    arm(1);
    repeat (5) tick();
    chk("mid_wait_busy", busy, 1);
    reset = 1'b1;
    tick();
    mw.delete();
    chk("rstw_busy", busy, 0);
    chk("rstw_walls", walls, 0);
    chk("rstw_count", wall_count, 0);
    chk("rstw_req", cand_req, 0);
    chk("rstw_chk_xy", chk_xy, 0);
    reset = 1'b0;
    tick();

    // Four apples during one WAIT: exactly one extra spawn afterwards
    arm(1);
    for (int i = 0; i < 4; i++) begin apple(); tick(); end
    wait_req(n);
    chk("pend_delay", n, SD - 8);
    cq.push_back(pick_legal()); hq.push_back(1'b0);
    run_spawn();
    wait_req(n);
    chk("pend_second_delay", n, SD + 1);
    cq.push_back(pick_legal()); hq.push_back(1'b0);
    run_spawn();
    seen = 1'b0;
    for (int i = 0; i < SD + 10; i++) begin tick(); if (busy) seen = 1'b1; end
    chk("pend_no_third", seen, 0);

    // Randomized spawns with random bounds, head and checker hits
    for (int r = 0; r < 8; r++) begin
      XMIN = 4'($urandom_range(0, 3));  XMAX = 4'($urandom_range(11, 15));
      YMIN = 4'($urandom_range(0, 3));  YMAX = 4'($urandom_range(11, 15));
      snake_head_x = 4'($urandom_range(0, 15));
      snake_head_y = 4'($urandom_range(0, 15));
      arm(1);
      wait_req(n);
      chk("rand_delay", n, SD);
      for (int i = 0; i < MT; i++) begin
        c = 8'($urandom_range(0, 255));
        cq.push_back(c);
        hq.push_back(in_list(c) || ($urandom_range(0, 3) == 0));
      end
      run_spawn();
    end
    XMIN = 4'd0; XMAX = 4'd15; YMIN = 4'd0; YMAX = 4'd15;
    snake_head_x = 4'd3; snake_head_y = 4'd3;

    // Fill the list, then spawning must be blocked
    while (mw.size() < MW) spawn_one_legal();
    chk("full_count", wall_count, MW);
    wsnap = walls;
    apple(); apple();
    seen = 1'b0;
    for (int i = 0; i < SD + 10; i++) begin
      if (busy || cand_req || place_fail) seen = 1'b1;
      tick();
    end
    chk("full_blocked", seen, 0);
    chk("full_walls", walls, exp_walls());
    chk("full_count_hold", wall_count, MW);
    chk("full_oldest", walls[(MW-1)*8 +: 8], mw[MW-1]);
    chk("full_stable", walls, wsnap);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
